// File: rtl/serial_bit_feeder.sv
// Parallel-in/serial-out feeder for the 101 detector: WIDTH-bit words in, MSB-first bits out on x.
// Optional even-parity trailer bit per frame when SER_PARITY_EN is defined.
module serial_bit_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifndef SER_PARITY_EN
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
`endif

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    count;
`ifdef SER_PARITY_EN
    logic             par;
`endif
    logic             accept;

    assign state_dbg = state;

    // Handshake: a word transfers on any rising edge where din_valid && din_ready;
    // din_valid may drop without a transfer, and din is ignored unless din_ready is high.
    always_comb begin
        din_ready = 1'b0;
        if (rst) begin
            case (state)
                IDLE:   din_ready = 1'b1;
`ifdef SER_PARITY_EN
                PARITY: din_ready = 1'b1;
                SHIFT:  din_ready = 1'b0;
`else
                SHIFT:  din_ready = (count == LAST_IDX);
`endif
                default: din_ready = 1'b0;
            endcase
        end
    end

    assign accept = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            count   <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
            busy    <= 1'b0;
`ifdef SER_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (accept) begin
            // Load path covers both IDLE and the zero-bubble reload at frame end.
            state   <= SHIFT;
            sreg    <= din;
            count   <= '0;
            x       <= din[WIDTH-1];
            x_valid <= 1'b1;
            x_last  <= 1'b0;
            busy    <= 1'b1;
`ifdef SER_PARITY_EN
            par     <= ^din;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (count != LAST_IDX) begin
                        sreg  <= sreg << 1;
                        x     <= sreg[WIDTH-2];
                        count <= count + 1'b1;
`ifdef SER_PARITY_EN
                        x_last <= 1'b0;
`else
                        x_last <= (count == PRE_LAST);
`endif
                    end else begin
`ifdef SER_PARITY_EN
                        state  <= PARITY;
                        x      <= par;
                        x_last <= 1'b1;
                        count  <= count + 1'b1;
`else
                        state   <= IDLE;
                        sreg    <= '0;
                        count   <= '0;
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        x_last  <= 1'b0;
                        busy    <= 1'b0;
`endif
                    end
                end
                default: begin
                    // IDLE, the parity cycle without a new word, and illegal encodings.
                    state   <= IDLE;
                    sreg    <= '0;
                    count   <= '0;
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    x_last  <= 1'b0;
                    busy    <= 1'b0;
`ifdef SER_PARITY_EN
                    par     <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: scoreboard of expected {x_last, x} per valid cycle.
// Also compiles with SER_PARITY_EN defined to cover the parity trailer.
module tb_serial_bit_feeder;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         x;
    logic         x_valid;
    logic         x_last;
    logic         busy;
    logic [1:0]   state_dbg;

    serial_bit_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .x_last    (x_last),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];

    int         run_len;
    int         last_run;
    int         ready_in_frame;
    int         frame_bit;
    logic [1:0] det_hist;
    int         det_hits;
    int         det_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) begin
`ifdef SER_PARITY_EN
            exp_q.push_back({1'b0, w[W-1-k]});
`else
            exp_q.push_back({(k == W - 1), w[W-1-k]});
`endif
        end
`ifdef SER_PARITY_EN
        exp_q.push_back({1'b1, ^w});
`endif
    endtask

    task automatic clear_stats();
        run_len        = 0;
        last_run       = 0;
        ready_in_frame = 0;
        frame_bit      = 0;
        det_hist       = 2'b00;
        det_hits       = 0;
        det_idx        = -1;
    endtask

    // driver: present a word and hold it until the DUT takes it
    task automatic send_word(input logic [W-1:0] w, input bit hold);
        bit ok;
        ok = 1'b0;
        din = w;
        din_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", {31'b0, ok}, 32'd1);
        if (ok) push_word(w);
        @(posedge clk);
        #1;
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!x_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        check("busy_eq_valid", {31'b0, busy}, {31'b0, x_valid});
        if (x_valid) begin
            run_len++;
            if (din_ready) ready_in_frame++;
            if (exp_q.size() == 0) begin
                check("unexpected_bit", {31'b0, x_valid}, 32'd0);
            end else begin
                check("bit", {30'b0, x_last, x}, {30'b0, exp_q.pop_front()});
            end
            if (x && det_hist == 2'b10) begin
                det_hits++;
                det_idx = frame_bit;
            end
            det_hist = {det_hist[0], x};
            frame_bit = x_last ? 0 : frame_bit + 1;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    initial begin
        clear_stats();
        rst = 1'b0;
        din = 8'hA5;
        din_valid = 1'b1;

        // reset held for two edges with din_valid high
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, din_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_ready2", {31'b0, din_ready}, 32'd0);
        check("rst_x", {31'b0, x}, 32'd0);
        check("rst_valid", {31'b0, x_valid}, 32'd0);
        check("rst_last", {31'b0, x_last}, 32'd0);
        check("rst_state", {30'b0, state_dbg}, 32'd0);
        rst = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_ready", {31'b0, din_ready}, 32'd1);
        check("idle_x", {31'b0, x}, 32'd0);
        @(posedge clk);
        #1;

        // single word
        clear_stats();
        send_word(8'hA5, 1'b0);
        wait_idle();
        check("single_len", last_run, FL);
        check("single_ready_cnt", ready_in_frame, 32'd1);
        check("single_state", {30'b0, state_dbg}, 32'd0);

        // back-to-back, valid held high across the boundary
        clear_stats();
        send_word(8'hA5, 1'b1);
        send_word(8'h5A, 1'b0);
        wait_idle();
        check("b2b_len", last_run, 2 * FL);
        check("b2b_ready_cnt", ready_in_frame, 32'd2);

        // stream into a 101 detector model
        clear_stats();
        send_word(8'h05, 1'b0);
        wait_idle();
        check("det_hits", det_hits, 32'd1);
        check("det_idx", det_idx, W - 1);

        // valid pulses low then high again before acceptance
        clear_stats();
        din = 8'h3C;
        din_valid = 1'b1;
        #1;
        din_valid = 1'b0;
        send_word(8'hC3, 1'b0);
        wait_idle();
        check("c3_len", last_run, FL);

        // reset in the middle of a frame
        clear_stats();
        send_word(8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_ready", {31'b0, din_ready}, 32'd0);
        @(negedge clk);
        check("midrst_valid", {31'b0, x_valid}, 32'd0);
        check("midrst_last", {31'b0, x_last}, 32'd0);
        check("midrst_x", {31'b0, x}, 32'd0);
        check("midrst_state", {30'b0, state_dbg}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
        send_word(8'h81, 1'b0);
        wait_idle();
        check("after_rst_len", last_run, FL);

`ifdef SER_PARITY_EN
        // odd-weight word gives a set parity bit
        clear_stats();
        send_word(8'h07, 1'b0);
        wait_idle();
        check("par07_len", last_run, FL);
`endif

        // random words back-to-back
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            send_word(W'($urandom_range(0, 255)), (i != 3));
        end
        wait_idle();
        check("rand_len", last_run, 4 * FL);

        check("exp_q_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
